// File: rtl/regfile_sched_pkg.sv
// Shared types and helpers for the register-bank access scheduler.
package regfile_sched_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD      = 3'd2,
    RD_CAP  = 3'd3,
    RD_DONE = 3'd4
  } sched_state_t;

  localparam int WR_LATENCY = 1;
  localparam int RD_LATENCY = 3;
  localparam int MAX_REGS   = 16;

  // Out-of-range addresses decode to all-zero so no register is touched.
  function automatic logic [MAX_REGS-1:0] onehot_decode(input int unsigned addr,
                                                        input int unsigned num_regs);
    logic [MAX_REGS-1:0] dec;
    dec = '0;
    if (addr < num_regs && addr < MAX_REGS) dec[addr[3:0]] = 1'b1;
    return dec;
  endfunction

endpackage

// File: rtl/regfile_access_sched_rr_arb2.sv
// Two-requester round-robin arbiter; requester 0 (write) wins ties after reset.
// Pointer only moves on contested grants, and then points at the loser.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr;

  always_comb begin
    grant = req;
    if (req == 2'b11) grant = ptr ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (advance && req == 2'b11) begin
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/regfile_access_sched.sv
// Serialises one writer and one reader onto a single-port register bank.
// Write acks 1 cycle after acceptance, read valid 3 cycles after; requests wait in IDLE.
module regfile_access_sched
  import regfile_sched_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_req,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  output logic                wr_ack,
  input  logic                rd_req,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic                rd_valid,
  output logic [DATA_W-1:0]   rd_data,
  output logic [NUM_REGS-1:0] reg_wen,
  output logic [NUM_REGS-1:0] reg_ren,
  output logic [DATA_W-1:0]   reg_wdata,
  input  logic [DATA_W-1:0]   reg_rdata,
  input  logic [NUM_REGS-1:0] reg_err,
  output logic                collision_err,
  output logic                oob_err
);

  sched_state_t          state;
  logic [1:0]            grant;
  logic [NUM_REGS-1:0]   sel_q;
  logic [DATA_W-1:0]     wdata_q;
  logic                  addr_ok_q;
  logic [MAX_REGS-1:0]   acc_dec;
  logic                  acc_ok;
  logic                  err_hit;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     ({rd_req, wr_req}),
    .advance (state == IDLE),
    .grant   (grant)
  );

  always_comb begin
    acc_dec = onehot_decode(32'(grant[1] ? rd_addr : wr_addr), NUM_REGS);
    acc_ok  = |acc_dec;
  end

  // Only a definite 1 counts; undriven or unknown error lines are ignored.
  always_comb begin
    err_hit = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reg_err[i] === 1'b1) err_hit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      sel_q         <= '0;
      wdata_q       <= '0;
      addr_ok_q     <= 1'b0;
      rd_data       <= '0;
      collision_err <= 1'b0;
      oob_err       <= 1'b0;
    end else begin
      if (err_hit) collision_err <= 1'b1;
      case (state)
        IDLE: begin
          if (grant != 2'b00) begin
            sel_q     <= acc_dec[NUM_REGS-1:0];
            addr_ok_q <= acc_ok;
            if (!acc_ok) oob_err <= 1'b1;
            if (grant[0]) begin
              wdata_q <= wr_data;
              state   <= WR;
            end else begin
              state <= RD;
            end
          end
        end
        WR:      state <= IDLE;
        RD:      state <= RD_CAP;
        RD_CAP: begin
          rd_data <= addr_ok_q ? reg_rdata : '0;
          state   <= RD_DONE;
        end
        RD_DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Enables are pure decodes of state, so write and read enables cannot overlap.
  assign reg_wen   = (state == WR) ? sel_q : '0;
  assign reg_ren   = (state == RD || state == RD_CAP) ? sel_q : '0;
  assign reg_wdata = wdata_q;
  assign wr_ack    = (state == WR);
  assign rd_valid  = (state == RD_DONE);

endmodule

// File: tb/tb_regfile_access_sched.sv
// Directed bench: an 8-register and a 6-register scheduler share stimulus, each with its own bank model.
module tb_regfile_access_sched;
  import regfile_sched_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_req = 1'b0, rd_req = 1'b0;
  logic [2:0]  wr_addr = '0, rd_addr = '0;
  logic [15:0] wr_data = '0;
  logic        err_en = 1'b1;
  logic [7:0]  err_val = '0;
  wire  [7:0]  reg_err = err_en ? err_val : 8'bz;

  logic        wr_ack, rd_valid, collision_err, oob_err;
  logic [15:0] rd_data, reg_wdata;
  logic [7:0]  reg_wen, reg_ren;
  logic        wr_ack_6, rd_valid_6, collision_err_6, oob_err_6;
  logic [15:0] rd_data_6, reg_wdata_6;
  logic [5:0]  reg_wen_6, reg_ren_6;

  logic [15:0] mem8 [8];
  logic [15:0] mem6 [6];
  logic [15:0] drv8, drv6;
  wire  [15:0] bus8 = (|reg_ren)   ? drv8 : 16'bz;
  wire  [15:0] bus6 = (|reg_ren_6) ? drv6 : 16'bz;

  int   n_checks = 0;
  int   n_errors = 0;
  logic overlap = 1'b0;

  always #5 clk = ~clk;

  regfile_access_sched #(.NUM_REGS(8), .ADDR_W(3), .DATA_W(16)) u_dut (
    .clk(clk), .reset(reset),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .reg_wen(reg_wen), .reg_ren(reg_ren), .reg_wdata(reg_wdata), .reg_rdata(bus8),
    .reg_err(reg_err), .collision_err(collision_err), .oob_err(oob_err)
  );

  regfile_access_sched #(.NUM_REGS(6), .ADDR_W(3), .DATA_W(16)) u_dut6 (
    .clk(clk), .reset(reset),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack_6),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid_6), .rd_data(rd_data_6),
    .reg_wen(reg_wen_6), .reg_ren(reg_ren_6), .reg_wdata(reg_wdata_6), .reg_rdata(bus6),
    .reg_err(reg_err[5:0]), .collision_err(collision_err_6), .oob_err(oob_err_6)
  );

  // Bank models: registered write, combinational read onto a tristated bus.
  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) if (reg_wen[i]) mem8[i] <= reg_wdata;
    for (int i = 0; i < 6; i++) if (reg_wen_6[i]) mem6[i] <= reg_wdata_6;
    if (((|reg_wen) && (|reg_ren)) || $countones(reg_wen) > 1 || $countones(reg_ren) > 1 ||
        ((|reg_wen_6) && (|reg_ren_6)) || $countones(reg_wen_6) > 1 || $countones(reg_ren_6) > 1)
      overlap <= 1'b1;
  end

  always_comb begin
    drv8 = '0;
    drv6 = '0;
    for (int i = 0; i < 8; i++) if (reg_ren[i]) drv8 = mem8[i];
    for (int i = 0; i < 6; i++) if (reg_ren_6[i]) drv6 = mem6[i];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // kind: 1 = wr_ack seen, 2 = rd_valid seen, 0 = nothing within the budget.
  task automatic wait_done(output int kind, output int cycles);
    kind = 0;
    cycles = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      cycles++;
      if (wr_ack) begin kind = 1; break; end
      if (rd_valid) begin kind = 2; break; end
    end
  endtask

  task automatic do_write(input logic [2:0] a, input logic [15:0] d,
                          input logic [7:0] exp_wen, input string tag);
    int k, c;
    wr_addr = a; wr_data = d; wr_req = 1'b1;
    wait_done(k, c);
    check({tag, "_kind"}, k, 1);
    check({tag, "_lat"}, c, WR_LATENCY);
    check({tag, "_wen"}, reg_wen, exp_wen);
    wr_req = 1'b0;
    tick();
  endtask

  task automatic do_read(input logic [2:0] a, input logic [15:0] exp_d, input string tag);
    int k, c;
    rd_addr = a; rd_req = 1'b1;
    wait_done(k, c);
    check({tag, "_kind"}, k, 2);
    check({tag, "_lat"}, c, RD_LATENCY);
    check({tag, "_data"}, rd_data, exp_d);
    rd_req = 1'b0;
    tick();
  endtask

  initial begin
    int k, c;
    logic seen;

    repeat (3) tick();
    check("rst_flags", {wr_ack, rd_valid, collision_err, oob_err}, 4'b0000);
    check("rst_en", {reg_wen, reg_ren}, 16'h0000);
    check("rst_data", {rd_data, reg_wdata}, 32'h0);
    reset = 1'b0;

    do_write(3'd3, 16'hA5A5, 8'b0000_1000, "wr3");
    do_read(3'd3, 16'hA5A5, "rd3");

    // Contested same-address access: pointer decides the order.
    do_write(3'd3, 16'h1111, 8'h08, "pre");
    reset_pulse();
    wr_addr = 3'd3; wr_data = 16'h2222; rd_addr = 3'd3;
    wr_req = 1'b1; rd_req = 1'b1;
    wait_done(k, c);
    check("sim1_first", k, 1);
    wr_req = 1'b0;
    wait_done(k, c);
    check("sim1_second", k, 2);
    check("sim1_data", rd_data, 16'h2222);
    wr_data = 16'h4444;
    wr_req = 1'b1;
    wait_done(k, c);
    check("sim2_first", k, 2);
    check("sim2_data", rd_data, 16'h2222);
    rd_req = 1'b0;
    wait_done(k, c);
    check("sim2_second", k, 1);
    wr_req = 1'b0;
    tick();
    do_read(3'd3, 16'h4444, "sim2_after");

    // Fairness with both requesters always asking.
    reset_pulse();
    wr_addr = 3'd1; wr_data = 16'hBEEF; rd_addr = 3'd1;
    wr_req = 1'b1; rd_req = 1'b1;
    for (int g = 0; g < 8; g++) begin
      wait_done(k, c);
      check($sformatf("fair_g%0d", g), k, (g % 2 == 0) ? 1 : 2);
      if (k == 2) check($sformatf("fair_d%0d", g), rd_data, 16'hBEEF);
    end
    wr_req = 1'b0; rd_req = 1'b0;
    tick();
    check("no_overlap", overlap, 1'b0);

    // Reset while the read is in its capture cycle.
    rd_addr = 3'd1; rd_req = 1'b1;
    tick();
    tick();
    check("cap_ren", reg_ren, 8'h02);
    reset = 1'b1; rd_req = 1'b0;
    tick();
    reset = 1'b0;
    check("abort_ren", reg_ren, 8'h00);
    check("abort_valid", rd_valid, 1'b0);
    check("abort_data", rd_data, 16'h0000);
    seen = 1'b0;
    repeat (5) begin
      tick();
      if (rd_valid) seen = 1'b1;
    end
    check("abort_no_valid", seen, 1'b0);
    wr_addr = 3'd0; wr_data = 16'h0F0F; rd_addr = 3'd0;
    wr_req = 1'b1; rd_req = 1'b1;
    wait_done(k, c);
    check("abort_ptr", k, 1);
    wr_req = 1'b0;
    wait_done(k, c);
    check("abort_rd", rd_data, 16'h0F0F);
    rd_req = 1'b0;
    tick();

    // Out of range on the 6-register instance.
    wr_addr = 3'd7; wr_data = 16'h7777; wr_req = 1'b1;
    wait_done(k, c);
    check("oob_wr_kind", k, 1);
    check("oob_wr_ack6", wr_ack_6, 1'b1);
    check("oob_wen6", reg_wen_6, 6'b0);
    check("oob_wen8", reg_wen, 8'h80);
    check("oob_flag6", oob_err_6, 1'b1);
    check("oob_flag8", oob_err, 1'b0);
    wr_req = 1'b0;
    tick();
    rd_addr = 3'd6; rd_req = 1'b1;
    wait_done(k, c);
    check("oob_rd_valid6", rd_valid_6, 1'b1);
    check("oob_rd_data6", rd_data_6, 16'h0000);
    rd_req = 1'b0;
    tick();
    do_write(3'd2, 16'h1234, 8'h04, "oob_after");
    check("oob_sticky", oob_err_6, 1'b1);
    reset_pulse();
    check("oob_cleared", oob_err_6, 1'b0);

    // Error monitor.
    err_en = 1'b0;
    repeat (3) tick();
    check("err_z_clear", collision_err, 1'b0);
    err_en = 1'b1; err_val = 8'h04;
    tick();
    err_val = 8'h00;
    tick();
    check("err_set8", collision_err, 1'b1);
    check("err_set6", collision_err_6, 1'b1);
    err_en = 1'b0;
    repeat (2) tick();
    check("err_sticky", collision_err, 1'b1);
    err_en = 1'b1;
    reset_pulse();
    check("err_reset", collision_err, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
